// File: rtl/uart_frame_loader_if.sv
// UART byte input and SDRAM host write port of the frame loader.
// master: loader side; slave: UART receiver / SDRAM controller side.
interface uart_frame_loader_if #(
   parameter int ADDR_WIDTH = 24
);
   logic                  rx_valid;
   logic [7:0]            rx_byte;
   logic                  wr_busy;
   logic                  wr_enable;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [15:0]           wr_data;

   modport master (
      input  rx_valid, rx_byte, wr_busy,
      output wr_enable, wr_addr, wr_data
   );

   modport slave (
      output rx_valid, rx_byte, wr_busy,
      input  wr_enable, wr_addr, wr_data
   );
endinterface

// File: rtl/uart_frame_loader.sv
// Packs UART bytes (low first) into 16-bit words and writes one frame to SDRAM.
// Optional preamble hunt (0xA5,0x5A) enabled by UART_FRAME_LOADER_SYNC_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOAD  | collecting bytes, no write outstanding
// ST_WRITE | write request outstanding, bytes still collected
// ST_DONE  | frame complete, bytes ignored, no writes
// ST_HUNT  | waiting for 0xA5,0x5A preamble (sync build only)
module uart_frame_loader #(
   parameter int FRAME_WORDS = 19220,
   parameter int ADDR_WIDTH  = 24,
   parameter int GAP_TIMEOUT = 21800
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    restart_i,
   uart_frame_loader_if.master     bus,
   output logic                    frame_ready_o,
   output logic [ADDR_WIDTH-1:0]   words_written_o,
   output logic                    overflow_o
);
   localparam int GW = $clog2(GAP_TIMEOUT + 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] FRAME_CNT = ADDR_WIDTH'(FRAME_WORDS);

`ifdef UART_FRAME_LOADER_SYNC_EN
   typedef enum logic [1:0] {ST_LOAD, ST_WRITE, ST_DONE, ST_HUNT} state_t;
   localparam state_t INIT_STATE = ST_HUNT;
   logic seen_a5_q, seen_a5_d;
`else
   typedef enum logic [1:0] {ST_LOAD, ST_WRITE, ST_DONE} state_t;
   localparam state_t INIT_STATE = ST_LOAD;
`endif

   state_t                state_q, state_d;
   logic                  phase_q, phase_d;
   logic [7:0]            low_q, low_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]           wr_data_q, wr_data_d;
   logic [ADDR_WIDTH-1:0] words_q, words_d;
   logic                  frame_ready_q, frame_ready_d;
   logic                  overflow_q, overflow_d;
   logic                  word_done;
   logic                  accept;
   logic                  last_word;

   assign accept    = wr_en_q && !bus.wr_busy;
   assign last_word = (words_q + ADDR_WIDTH'(1)) == FRAME_CNT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= INIT_STATE;
         phase_q       <= 1'b0;
         low_q         <= '0;
         gap_q         <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         words_q       <= '0;
         frame_ready_q <= 1'b0;
         overflow_q    <= 1'b0;
`ifdef UART_FRAME_LOADER_SYNC_EN
         seen_a5_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         low_q         <= low_d;
         gap_q         <= gap_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         words_q       <= words_d;
         frame_ready_q <= frame_ready_d;
         overflow_q    <= overflow_d;
`ifdef UART_FRAME_LOADER_SYNC_EN
         seen_a5_q     <= seen_a5_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      low_d         = low_q;
      gap_d         = gap_q;
      wr_en_d       = wr_en_q;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      words_d       = words_q;
      frame_ready_d = frame_ready_q;
      overflow_d    = overflow_q;
      word_done     = 1'b0;
`ifdef UART_FRAME_LOADER_SYNC_EN
      seen_a5_d     = seen_a5_q;
`endif
      if (restart_i) begin
         // a write accepted on this same edge still reaches SDRAM but is not counted
         state_d       = INIT_STATE;
         phase_d       = 1'b0;
         gap_d         = '0;
         wr_en_d       = 1'b0;
         words_d       = '0;
         frame_ready_d = 1'b0;
         overflow_d    = 1'b0;
`ifdef UART_FRAME_LOADER_SYNC_EN
         seen_a5_d     = 1'b0;
`endif
      end else begin
         if (state_q == ST_LOAD || state_q == ST_WRITE) begin
            if (bus.rx_valid) begin
               if (!phase_q) begin
                  low_d   = bus.rx_byte;
                  phase_d = 1'b1;
                  gap_d   = GAP_LOAD;
               end else begin
                  phase_d   = 1'b0;
                  gap_d     = '0;
                  word_done = 1'b1;
               end
            end else if (phase_q) begin
               if (gap_q == '0) phase_d = 1'b0;
               else             gap_d   = gap_q - GW'(1);
            end
         end

         case (state_q)
            ST_LOAD: begin
               if (word_done) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = words_q;
                  wr_data_d = {bus.rx_byte, low_q};
                  state_d   = ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (word_done) overflow_d = 1'b1;
               if (accept) begin
                  wr_en_d       = 1'b0;
                  frame_ready_d = last_word;
                  if (words_q < FRAME_CNT) words_d = words_q + ADDR_WIDTH'(1);
                  if (last_word) begin
                     state_d = ST_DONE;
                     gap_d   = GAP_LOAD;
                  end else begin
                     state_d = ST_LOAD;
                  end
               end
            end
`ifdef UART_FRAME_LOADER_SYNC_EN
            ST_DONE: begin
               // frame_ready stays up until the next frame's first word is accepted
               if (bus.rx_valid) begin
                  gap_d = GAP_LOAD;
               end else if (gap_q == '0) begin
                  state_d   = ST_HUNT;
                  words_d   = '0;
                  phase_d   = 1'b0;
                  seen_a5_d = 1'b0;
               end else begin
                  gap_d = gap_q - GW'(1);
               end
            end
            ST_HUNT: begin
               if (bus.rx_valid) begin
                  if (bus.rx_byte == 8'hA5) begin
                     seen_a5_d = 1'b1;
                  end else if (seen_a5_q && bus.rx_byte == 8'h5A) begin
                     seen_a5_d = 1'b0;
                     phase_d   = 1'b0;
                     state_d   = ST_LOAD;
                  end else begin
                     seen_a5_d = 1'b0;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.wr_enable   = wr_en_q;
   assign bus.wr_addr     = wr_addr_q;
   assign bus.wr_data     = wr_data_q;
   assign frame_ready_o   = frame_ready_q;
   assign words_written_o = words_q;
   assign overflow_o      = overflow_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed/randomized bench for uart_frame_loader: byte-pair model, write scoreboard.
module tb_uart_frame_loader;
   localparam int FW  = 19220;
   localparam int AW  = 24;
   localparam int GAP = 21800;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          restart = 1'b0;
   logic          frame_ready;
   logic [AW-1:0] words_written;
   logic          overflow;

   uart_frame_loader_if #(.ADDR_WIDTH(AW)) bus ();

   uart_frame_loader #(.FRAME_WORDS(FW), .ADDR_WIDTH(AW), .GAP_TIMEOUT(GAP)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .restart_i       (restart),
      .bus             (bus),
      .frame_ready_o   (frame_ready),
      .words_written_o (words_written),
      .overflow_o      (overflow)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int stab_bad = 0;
   int fr_bad = 0;

   logic [AW-1:0] acc_addr[$];
   logic [15:0]   acc_data[$];
   logic [15:0]   exp_words[$];
   logic          prev_en = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [15:0]   prev_data = '0;

   // scoreboard of accepted writes plus hold-stability and frame_ready consistency
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (bus.wr_enable && !bus.wr_busy) begin
            acc_addr.push_back(bus.wr_addr);
            acc_data.push_back(bus.wr_data);
         end
         if (prev_en && bus.wr_enable && (bus.wr_addr !== prev_addr || bus.wr_data !== prev_data))
            stab_bad++;
         if (frame_ready !== (words_written == AW'(FW)))
            fr_bad++;
      end
      prev_en   = bus.wr_enable;
      prev_addr = bus.wr_addr;
      prev_data = bus.wr_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic sync_hunt();
`ifdef UART_FRAME_LOADER_SYNC_EN
      send_byte(8'h00);
      send_byte(8'hA5);
      send_byte(8'hA5);
      send_byte(8'h5A);
`endif
   endtask

   initial begin
      logic [7:0] b0, b1, b2, b3;
      int en_low, bad, base;
      logic [7:0] bytes[$];

      bus.rx_valid = 1'b0;
      bus.rx_byte  = '0;
      bus.wr_busy  = 1'b0;

      #3;
      chk("rst_wr_enable", 32'(bus.wr_enable), 32'd0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
      chk("rst_frame_ready", 32'(frame_ready), 32'd0);
      chk("rst_words", 32'(words_written), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // first word, low byte first, one-cycle request latency
      sync_hunt();
      acc_addr.delete(); acc_data.delete();
      send_byte(8'h34);
      send_byte(8'h12);
      chk("t1_wr_enable", 32'(bus.wr_enable), 32'd1);
      chk("t1_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("t1_wr_data", 32'(bus.wr_data), 32'h1234);
      idle(1);
      chk("t1_wr_enable_drop", 32'(bus.wr_enable), 32'd0);
      chk("t1_words", 32'(words_written), 32'd1);
      chk("t1_acc_count", 32'(acc_addr.size()), 32'd1);

      // busy back-pressure holds the request
      b0 = 8'($urandom); b1 = 8'($urandom);
      bus.wr_busy = 1'b1;
      send_byte(b0);
      send_byte(b1);
      chk("t2_wr_addr", 32'(bus.wr_addr), 32'd1);
      chk("t2_wr_data", 32'(bus.wr_data), 32'({b1, b0}));
      en_low = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.wr_enable !== 1'b1) en_low++;
         @(negedge clk);
      end
      chk("t2_enable_held", 32'(en_low), 32'd0);
      chk("t2_words_while_busy", 32'(words_written), 32'd1);
      bus.wr_busy = 1'b0;
      idle(1);
      chk("t2_enable_after_accept", 32'(bus.wr_enable), 32'd0);
      chk("t2_words", 32'(words_written), 32'd2);

      // lone low byte discarded after the gap timeout
      acc_addr.delete(); acc_data.delete();
      send_byte(8'h11);
      idle(GAP + 5);
      send_byte(8'h22);
      send_byte(8'h33);
      idle(2);
      chk("t3_acc_count", 32'(acc_addr.size()), 32'd1);
      chk("t3_wr_data", 32'(acc_data[0]), 32'h3322);
      chk("t3_wr_addr", 32'(acc_addr[0]), 32'd2);
      chk("t3_words", 32'(words_written), 32'd3);

      // overflow: second word completes while the first is still pending
      acc_addr.delete(); acc_data.delete();
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      bus.wr_busy = 1'b1;
      send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
      idle(2);
      chk("t4_overflow", 32'(overflow), 32'd1);
      chk("t4_wr_enable", 32'(bus.wr_enable), 32'd1);
      chk("t4_wr_data", 32'(bus.wr_data), 32'({b1, b0}));
      bus.wr_busy = 1'b0;
      idle(2);
      chk("t4_acc_count", 32'(acc_addr.size()), 32'd1);
      chk("t4_words", 32'(words_written), 32'd4);
      chk("t4_overflow_sticky", 32'(overflow), 32'd1);
      pulse_restart();
      chk("t4_overflow_cleared", 32'(overflow), 32'd0);
      chk("t4_words_cleared", 32'(words_written), 32'd0);
      sync_hunt();
      send_byte(8'hC3); send_byte(8'h3C);
      chk("t4_addr_after_restart", 32'(bus.wr_addr), 32'd0);
      chk("t4_data_after_restart", 32'(bus.wr_data), 32'h3CC3);

      // full frame of random bytes with random single-cycle gaps
      pulse_restart();
      sync_hunt();
      acc_addr.delete(); acc_data.delete();
      bytes.delete(); exp_words.delete();
      for (int i = 0; i < 2 * FW; i++) begin
         b0 = 8'($urandom);
         bytes.push_back(b0);
         send_byte(b0);
         if ($urandom_range(0, 7) == 0) idle(1);
      end
      for (int i = 0; i < FW; i++) exp_words.push_back({bytes[2*i+1], bytes[2*i]});
      idle(3);
      chk("t5_words", 32'(words_written), 32'(FW));
      chk("t5_frame_ready", 32'(frame_ready), 32'd1);
      chk("t5_acc_count", 32'(acc_addr.size()), 32'(FW));
      chk("t5_last_addr", 32'(acc_addr[acc_addr.size()-1]), 32'(FW - 1));
      bad = 0;
      for (int i = 0; i < acc_addr.size() && i < FW; i++)
         if (acc_addr[i] !== AW'(i) || acc_data[i] !== exp_words[i]) bad++;
      chk("t5_bad_entries", 32'(bad), 32'd0);
      base = acc_addr.size();
      for (int i = 0; i < 4; i++) send_byte(8'($urandom));
      idle(3);
      chk("t5_no_extra_writes", 32'(acc_addr.size()), 32'(base));
      chk("t5_enable_idle", 32'(bus.wr_enable), 32'd0);
      chk("t5_words_saturated", 32'(words_written), 32'(FW));

      // restart coinciding with acceptance: write lands, not counted
      pulse_restart();
      sync_hunt();
      acc_addr.delete(); acc_data.delete();
      send_byte(8'h5E); send_byte(8'hE5);
      chk("t6_enable", 32'(bus.wr_enable), 32'd1);
      pulse_restart();
      chk("t6_words", 32'(words_written), 32'd0);
      chk("t6_enable_drop", 32'(bus.wr_enable), 32'd0);
      chk("t6_frame_ready", 32'(frame_ready), 32'd0);
      chk("t6_write_landed", 32'(acc_addr.size()), 32'd1);
      sync_hunt();
      send_byte(8'h01); send_byte(8'h02);
      chk("t6_next_addr", 32'(bus.wr_addr), 32'd0);
      idle(1);
      chk("t6_words_after", 32'(words_written), 32'd1);

      chk("hold_stability", 32'(stab_bad), 32'd0);
      chk("frame_ready_consistency", 32'(fr_bad), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
